// File: rtl/modex_encrypt_writer.sv
// -----------------------------------------------------------------------------
// modex_encrypt_writer
// RSA encrypt/store stage. Takes one plaintext word m, computes c = m^E mod N
// with fixed-schedule square-and-multiply, and writes c as two bytes:
// c[15:8] at base address, c[7:0] at base address + 1 (wraps modulo 2^ADDR).
// Requests with m >= N are rejected with a one-cycle err pulse.
//
// Optional feature: define MODEX_TRIVIAL_BYPASS_EN so that m==0/1 skip the
// exponentiation (c == m since E > 0) and go straight to the byte writes.
//
// Ports:
//   i_clk        clock, rising edge
//   i_rst        asynchronous reset, active-high
//   i_in_valid   plaintext request valid
//   o_in_ready   idle, request can be accepted
//   i_in_data    plaintext m (ARQ bits)
//   i_in_addr    destination base address (high byte)
//   o_wr_en      memory byte write strobe
//   o_wr_addr    write address
//   o_wr_data    write byte
//   o_busy       request in flight (~o_in_ready)
//   o_done       pulse coincident with the low-byte write
//   o_err        pulse the cycle after a rejected request
// -----------------------------------------------------------------------------
module modex_encrypt_writer #(
   parameter int ARQ   = 16,
   parameter int ADDR  = 18,
   parameter int E     = 1243,
   parameter int N     = 1349,
   parameter int EXP_W = 11
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_in_valid,
   output logic            o_in_ready,
   input  logic [ARQ-1:0]  i_in_data,
   input  logic [ADDR-1:0] i_in_addr,
   output logic            o_wr_en,
   output logic [ADDR-1:0] o_wr_addr,
   output logic [7:0]      o_wr_data,
   output logic            o_busy,
   output logic            o_done,
   output logic            o_err
);

   localparam int SW = $clog2(ARQ + 1);
   localparam int CW = $clog2(EXP_W + 1);
   localparam logic [ARQ+1:0] NX = (ARQ+2)'(N);
   localparam logic [ARQ-1:0] NA = ARQ'(N);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_BIT, S_WR_HI, S_WR_LO} state_t;

   state_t          r_state;
   logic            r_ready, r_wr_en, r_done, r_err;
   logic [ADDR-1:0] r_wr_addr, r_addr;
   logic [7:0]      r_wr_data;
   logic [ARQ-1:0]  r_m, r_result, r_base;
   logic [ARQ-1:0]  r_mulp, r_muls;   // multiplier operands, consumed MSB-first
   logic [ARQ+1:0]  r_accp, r_accs;   // P = result*base, S = base*base
   logic [EXP_W-1:0] r_exp;
   logic [CW-1:0]   r_cnt;
   logic [SW-1:0]   r_step;

   logic [ARQ+1:0]  w_accp_nxt, w_accs_nxt;
   logic [ARQ-1:0]  w_res_fin;
   logic            w_trivial;

   // One interleaved modular-multiply step. acc < N on entry, so 2*acc + b < 3N
   // and two conditional subtractions restore acc < N.
   function automatic logic [ARQ+1:0] mstep(input logic [ARQ+1:0] acc,
                                            input logic           bit_i,
                                            input logic [ARQ-1:0] b);
      logic [ARQ+1:0] t;
      t = (acc << 1) + (bit_i ? {2'b00, b} : '0);
      if (t >= NX) t = t - NX;
      if (t >= NX) t = t - NX;
      return t;
   endfunction

   assign w_accp_nxt = mstep(r_accp, r_mulp[ARQ-1], r_base);
   assign w_accs_nxt = mstep(r_accs, r_muls[ARQ-1], r_base);
   assign w_res_fin  = r_exp[0] ? r_accp[ARQ-1:0] : r_result;

`ifdef MODEX_TRIVIAL_BYPASS_EN
   assign w_trivial = (i_in_data < ARQ'(2));
`else
   assign w_trivial = 1'b0;
`endif

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state   <= S_IDLE;
         r_ready   <= 1'b1;
         r_wr_en   <= 1'b0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
         r_wr_addr <= '0;
         r_wr_data <= '0;
         r_addr    <= '0;
         r_m       <= '0;
         r_result  <= '0;
         r_base    <= '0;
         r_mulp    <= '0;
         r_muls    <= '0;
         r_accp    <= '0;
         r_accs    <= '0;
         r_exp     <= '0;
         r_cnt     <= '0;
         r_step    <= '0;
      end else begin
         r_wr_en <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_in_valid) begin
                  if (i_in_data >= NA) begin
                     r_err <= 1'b1;
                  end else begin
                     r_m     <= i_in_data;
                     r_addr  <= i_in_addr;
                     r_ready <= 1'b0;
                     if (w_trivial) begin
                        // c == m: issue the high-byte write directly
                        r_result  <= i_in_data;
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= i_in_addr;
                        r_wr_data <= i_in_data[15:8];
                        r_state   <= S_WR_HI;
                     end else begin
                        r_state <= S_LOAD;
                     end
                  end
               end
            end
            S_LOAD: begin
               r_result <= ARQ'(1);
               r_base   <= r_m;
               r_mulp   <= ARQ'(1);
               r_muls   <= r_m;
               r_accp   <= '0;
               r_accs   <= '0;
               r_exp    <= EXP_W'(E);
               r_cnt    <= '0;
               r_step   <= '0;
               r_state  <= S_BIT;
            end
            S_BIT: begin
               if (r_step == SW'(ARQ)) begin
                  // Both products are complete; commit one exponent bit.
                  r_result <= w_res_fin;
                  r_base   <= r_accs[ARQ-1:0];
                  r_mulp   <= w_res_fin;
                  r_muls   <= r_accs[ARQ-1:0];
                  r_accp   <= '0;
                  r_accs   <= '0;
                  r_exp    <= r_exp >> 1;
                  r_cnt    <= r_cnt + CW'(1);
                  r_step   <= '0;
                  if (r_cnt == CW'(EXP_W - 1)) begin
                     r_wr_en   <= 1'b1;
                     r_wr_addr <= r_addr;
                     r_wr_data <= w_res_fin[15:8];
                     r_state   <= S_WR_HI;
                  end
               end else begin
                  r_accp <= w_accp_nxt;
                  r_accs <= w_accs_nxt;
                  r_mulp <= r_mulp << 1;
                  r_muls <= r_muls << 1;
                  r_step <= r_step + SW'(1);
               end
            end
            S_WR_HI: begin
               r_wr_en   <= 1'b1;
               r_wr_addr <= r_addr + ADDR'(1);
               r_wr_data <= r_result[7:0];
               r_done    <= 1'b1;
               r_state   <= S_WR_LO;
            end
            S_WR_LO: begin
               r_ready <= 1'b1;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_in_ready = r_ready;
   assign o_busy     = ~r_ready;
   assign o_wr_en    = r_wr_en;
   assign o_wr_addr  = r_wr_addr;
   assign o_wr_data  = r_wr_data;
   assign o_done     = r_done;
   assign o_err      = r_err;

endmodule

// File: tb/tb_modex_encrypt_writer.sv
// Bench for modex_encrypt_writer: table vectors, an m=0..255 sweep with random
// addresses, random full-range words, reset-abort and held-valid sequences.
// Expected ciphertext comes from a plain repeated-multiply model.
module tb_modex_encrypt_writer;
   localparam int N = 1349;
   localparam int E = 1243;
   localparam int D = 1927;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic [15:0] in_data = '0;
   logic [17:0] in_addr = '0;
   logic        in_ready, wr_en, busy, done, err;
   logic [17:0] wr_addr;
   logic [7:0]  wr_data;

   modex_encrypt_writer dut (
      .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(in_ready),
      .i_in_data(in_data), .i_in_addr(in_addr), .o_wr_en(wr_en),
      .o_wr_addr(wr_addr), .o_wr_data(wr_data), .o_busy(busy),
      .o_done(done), .o_err(err)
   );

   always #5 clk = ~clk;

   int nchk = 0, nerr = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Output log, sampled on the falling edge.
   int          wq_cyc[$];
   logic [17:0] wq_addr[$];
   logic [7:0]  wq_data[$];
   int          done_cyc[$], err_cyc[$];
   int          rdy_back = -1;
   int          busy_bad = 0;

   always @(negedge clk) begin
      if (wr_en) begin
         wq_cyc.push_back(cyc); wq_addr.push_back(wr_addr); wq_data.push_back(wr_data);
      end
      if (done) done_cyc.push_back(cyc);
      if (err)  err_cyc.push_back(cyc);
      if (in_ready && rdy_back < 0) rdy_back = cyc;
      if (busy !== ~in_ready) busy_bad++;
   end

   function automatic int powmod(int b, int e, int n);
      longint r = 1;
      for (int i = 0; i < e; i++) r = (r * b) % n;
      return int'(r);
   endfunction

   task automatic chk(input string nm, input longint got, input longint exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got=%0d expected=%0d", nm, got, exp);
      end
   endtask

   task automatic clear_logs();
      wq_cyc.delete(); wq_addr.delete(); wq_data.delete();
      done_cyc.delete(); err_cyc.delete(); rdy_back = -1;
   endtask

   // Present a request once ready; acc is the cycle index of acceptance (cycle 0).
   task automatic send(input logic [15:0] m, input logic [17:0] a, output int acc);
      int w = 0;
      @(negedge clk);
      while (!in_ready && w < 400) begin @(negedge clk); w++; end
      if (!in_ready) chk("ready_timeout", 0, 1);
      in_valid = 1'b1; in_data = m; in_addr = a;
      @(posedge clk); #1;
      acc = cyc - 1;
      clear_logs();
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic check_result(input string nm, input int acc, input logic [17:0] a,
                               input logic exp_err, input int exp_c, input int m);
      int hi_t;
      logic [17:0] lo_a;
      hi_t = 189;
`ifdef MODEX_TRIVIAL_BYPASS_EN
      if (m < 2) hi_t = 1;
`endif
      lo_a = a + 18'd1;
      while (cyc - acc < (exp_err ? 6 : hi_t + 4)) @(negedge clk);
      if (exp_err) begin
         chk({nm, "_err_cnt"}, err_cyc.size(), 1);
         if (err_cyc.size() > 0) chk({nm, "_err_cyc"}, err_cyc[0] - acc, 1);
         chk({nm, "_nwrites"}, wq_cyc.size(), 0);
         chk({nm, "_ready_kept"}, rdy_back - acc, 1);
      end else begin
         chk({nm, "_nwrites"}, wq_cyc.size(), 2);
         chk({nm, "_err_none"}, err_cyc.size(), 0);
         if (wq_cyc.size() == 2) begin
            chk({nm, "_hi_cyc"},  wq_cyc[0] - acc, hi_t);
            chk({nm, "_hi_addr"}, wq_addr[0], a);
            chk({nm, "_hi_data"}, wq_data[0], (exp_c >> 8) & 255);
            chk({nm, "_lo_cyc"},  wq_cyc[1] - acc, hi_t + 1);
            chk({nm, "_lo_addr"}, wq_addr[1], lo_a);
            chk({nm, "_lo_data"}, wq_data[1], exp_c & 255);
            chk({nm, "_decrypt"}, powmod({wq_data[0], wq_data[1]}, D, N), m);
         end
         chk({nm, "_done_cnt"}, done_cyc.size(), 1);
         if (done_cyc.size() > 0) chk({nm, "_done_cyc"}, done_cyc[0] - acc, hi_t + 1);
         chk({nm, "_ready_back"}, rdy_back - acc, hi_t + 2);
      end
   endtask

   task automatic run_vec(input string nm, input logic [15:0] m, input logic [17:0] a,
                          input logic exp_err, input int exp_c);
      int acc;
      send(m, a, acc);
      check_result(nm, acc, a, exp_err, exp_c, int'(m));
   endtask

   typedef struct {
      logic [15:0] m;
      logic [17:0] a;
      logic        err;
      int          c;
   } vec_t;

   initial begin
      vec_t tbl[6];
      int acc, second, ca, cb;
      logic [15:0] ma, mb;
      logic [17:0] aa, ab;

      tbl[0] = '{16'd1348,  18'h00100, 1'b0, 16'h0544};
      tbl[1] = '{16'd0,     18'h3FFFF, 1'b0, 0};
      tbl[2] = '{16'd1349,  18'h00010, 1'b1, 0};
      tbl[3] = '{16'd1,     18'h2AAAA, 1'b0, 1};
      tbl[4] = '{16'hFFFF,  18'h00000, 1'b1, 0};
      tbl[5] = '{16'd1347,  18'h1FFFF, 1'b0, powmod(1347, E, N)};

      // reset state
      repeat (3) @(negedge clk);
      chk("rst_ready", in_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_wr_en", wr_en, 0);
      chk("rst_wr_addr", wr_addr, 0);
      chk("rst_wr_data", wr_data, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      rst = 1'b0;

      for (int i = 0; i < 6; i++)
         run_vec($sformatf("tbl%0d", i), tbl[i].m, tbl[i].a, tbl[i].err, tbl[i].c);

      // sweep m = 0..255 with random addresses
      for (int m = 0; m < 256; m++)
         run_vec($sformatf("sweep%0d", m), 16'(m), 18'($urandom), 1'b0, powmod(m, E, N));

      // random full-range words (mostly rejected)
      for (int i = 0; i < 16; i++) begin
         logic [15:0] rm;
         rm = 16'($urandom);
         run_vec($sformatf("rnd%0d", i), rm, 18'($urandom), rm >= 16'(N),
                 (rm < 16'(N)) ? powmod(int'(rm), E, N) : 0);
      end

      // reset in the middle of a request
      send(16'd700, 18'h01234, acc);
      while (cyc - acc < 100) @(negedge clk);
      rst = 1'b1; #1;
      chk("midrst_ready", in_ready, 1);
      chk("midrst_busy", busy, 0);
      chk("midrst_wr_en", wr_en, 0);
      chk("midrst_wr_addr", wr_addr, 0);
      chk("midrst_wr_data", wr_data, 0);
      chk("midrst_done", done, 0);
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      clear_logs();
      repeat (200) @(negedge clk);
      chk("midrst_no_writes", wq_cyc.size(), 0);
      run_vec("after_rst", 16'd700, 18'h01234, 1'b0, powmod(700, E, N));

      // valid held high with changing data while busy
      ma = 16'($urandom_range(1348, 2)); aa = 18'($urandom);
      ca = powmod(int'(ma), E, N);
      @(negedge clk);
      in_valid = 1'b1; in_data = ma; in_addr = aa;
      @(posedge clk); #1;
      acc = cyc - 1;
      clear_logs();
      second = -1; mb = '0; ab = '0;
      while (second < 0 && cyc - acc < 400) begin
         @(negedge clk);
         mb = 16'($urandom_range(1348, 2)); ab = 18'($urandom);
         in_data = mb; in_addr = ab;
         if (in_ready) second = cyc - acc;
      end
      chk("hold_accept_cyc", second, 191);
      chk("hold_nwrites", wq_cyc.size(), 2);
      if (wq_cyc.size() == 2) begin
         chk("hold_hi_addr", wq_addr[0], aa);
         chk("hold_hi_data", wq_data[0], (ca >> 8) & 255);
         chk("hold_lo_data", wq_data[1], ca & 255);
      end
      cb = powmod(int'(mb), E, N);
      @(posedge clk); #1;
      acc = cyc - 1;
      clear_logs();
      @(negedge clk);
      in_valid = 1'b0;
      check_result("hold_next", acc, ab, 1'b0, cb, int'(mb));

      chk("busy_eq_not_ready", busy_bad, 0);
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule
